// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-I subset core with a shared request/ready memory port.
// Optional performance counters: define MIPS_MULTICYCLE_PERF_EN.
module mips_multicycle #(
    parameter int ADDR_WIDTH = 12,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] pc
`ifdef MIPS_MULTICYCLE_PERF_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           retired_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PC0 = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] rf [32];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];

    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_brk;
    logic is_ok;

    always_comb begin
        is_r    = 1'b0;
        is_addi = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        is_brk  = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24,
                    6'h25, 6'h2A, 6'h00: is_r = 1'b1;
                    6'h0D:               is_brk = 1'b1;
                    default:             ;
                endcase
            end
            6'h08:   is_addi = 1'b1;
            6'h23:   is_lw   = 1'b1;
            6'h2B:   is_sw   = 1'b1;
            6'h04:   is_beq  = 1'b1;
            6'h02:   is_j    = 1'b1;
            default: ;
        endcase
    end

    assign is_ok = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

    // One shared ALU; immediate add is the default for addi/lw/sw.
    logic [31:0] alu;
    always_comb begin
        alu = a + imm;
        if (is_r) begin
            case (funct)
                6'h20:   alu = a + b;
                6'h22:   alu = a - b;
                6'h24:   alu = a & b;
                6'h25:   alu = a | b;
                6'h2A:   alu = {31'd0, $signed(a) < $signed(b)};
                default: alu = b << shamt;
            endcase
        end
    end

    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        retire;

    assign wb_dst  = is_r ? rd : rt;
    assign wb_data = is_lw ? mdr : alu_out;
    assign retire  = (state == WRITEBACK)
                  || (state == EXECUTE && (is_beq || is_j))
                  || (state == MEMORY && is_sw && mem_ready);

    assign mem_addr  = (state == MEMORY) ? alu_out[ADDR_WIDTH+1:2] : pc;
    assign mem_we    = (state == MEMORY) && is_sw;
    assign mem_wdata = b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= PC0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            mem_req <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
`ifdef MIPS_MULTICYCLE_PERF_EN
            cycle_count   <= '0;
            retired_count <= '0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // mem_req is low only in the first cycle out of reset
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + ADDR_WIDTH'(1);
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a   <= rf[rs];
                    b   <= rf[rt];
                    imm <= {{16{ir[15]}}, ir[15:0]};
                    if (is_ok) begin
                        state <= EXECUTE;
                    end else begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        illegal <= !is_brk;
                    end
                end
                EXECUTE: begin
                    alu_out <= alu;
                    if (is_lw || is_sw) begin
                        state   <= MEMORY;
                        mem_req <= 1'b1;
                    end else if (is_beq || is_j) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                        if (is_j)
                            pc <= ir[ADDR_WIDTH-1:0];
                        else if (a == b)
                            pc <= pc + imm[ADDR_WIDTH-1:0];
                    end else begin
                        state <= WRITEBACK;
                    end
                end
                MEMORY: begin
                    if (mem_ready) begin
                        mdr <= mem_rdata;
                        if (is_sw) begin
                            state <= FETCH;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= WRITEBACK;
                        end
                    end
                end
                WRITEBACK: begin
                    if (wb_dst != 5'd0) rf[wb_dst] <= wb_data;
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
                HALT: mem_req <= 1'b0;
                default: begin
                    state   <= HALT;
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                    illegal <= 1'b1;
                end
            endcase
`ifdef MIPS_MULTICYCLE_PERF_EN
            if (!halted) cycle_count <= cycle_count + 32'd1;
            if (retire) retired_count <= retired_count + 32'd1;
`endif
        end
    end

`ifndef MIPS_MULTICYCLE_PERF_EN
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench for mips_multicycle: ISA-level model predicts every
// memory access; a memory/monitor process checks each accepted access.
module tb_mips_multicycle;

    localparam int AW = 12;
    localparam int MW = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          halted;
    logic          illegal;
    logic [AW-1:0] pc;
`ifdef MIPS_MULTICYCLE_PERF_EN
    logic [31:0]   cycle_count;
    logic [31:0]   retired_count;
`endif

    mips_multicycle #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .illegal   (illegal),
        .pc        (pc)
`ifdef MIPS_MULTICYCLE_PERF_EN
        ,
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        int          addr;
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];

    int vectors = 0;
    int miscompares = 0;
    int wait_pct = 0;
    int fixed_wait = -1;
    bit hold_wr = 1'b0;

    bit exp_hlt;
    bit exp_ill;
    int exp_pc;
    int exp_ret;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int f, input int s,
                                          input int t, input int d,
                                          input int sh);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(f)};
    endfunction

    function automatic logic [31:0] enc_i(input int o, input int s,
                                          input int t,
                                          input logic [15:0] im);
        return {6'(o), 5'(s), 5'(t), im};
    endfunction

    function automatic logic [31:0] enc_j(input int tg);
        return {6'h02, 26'(tg)};
    endfunction

    // Memory model and monitor: decides mem_ready, checks every
    // accepted access against the scoreboard and the cycle gap.
    initial begin
        int   cyc = 0;
        int   last_acc = -1;
        int   waits = 0;
        bit   pend = 1'b0;
        logic pend_we = 1'b0;
        logic [AW-1:0] pend_addr = '0;
        logic [31:0]   pend_wdata = '0;
        logic rdy;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset)
                rdy = 1'b1;
            else if (sbq.size() == 0 || (hold_wr && mem_req && mem_we))
                rdy = 1'b0;
            else if (fixed_wait >= 0)
                rdy = (waits >= fixed_wait);
            else
                rdy = ($urandom_range(0, 99) >= wait_pct);
            mem_ready = rdy;
            if (!reset) begin
                pend = 1'b0;
                waits = 0;
                last_acc = -1;
            end else if (mem_req) begin
                if (pend) begin
                    check("hold_addr", 32'(mem_addr), 32'(pend_addr));
                    check("hold_we", 32'(mem_we), 32'(pend_we));
                    if (pend_we)
                        check("hold_wdata", mem_wdata, pend_wdata);
                end
                if (rdy) begin
                    e = sbq.pop_front();
                    check("acc_we", 32'(mem_we), 32'(e.we));
                    check("acc_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("acc_wdata", mem_wdata, e.data);
                    if (e.gap >= 0 && last_acc >= 0)
                        check("acc_gap", 32'(cyc - last_acc),
                              32'(e.gap + waits));
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem[mem_addr];
                    last_acc = cyc;
                    waits = 0;
                    pend = 1'b0;
                end else begin
                    waits++;
                    pend = 1'b1;
                    pend_we = mem_we;
                    pend_addr = mem_addr;
                    pend_wdata = mem_wdata;
                end
            end else begin
                if (pend) check("req_held", 32'(mem_req), 32'd1);
                pend = 1'b0;
            end
        end
    end

    // ISA-level reference: executes ref_mem, queues every expected access.
    // gap = cycles since previous access with no wait-states.
    task automatic model_run(input int max_steps);
        logic [31:0] r [32];
        logic [31:0] ins;
        logic [31:0] se;
        logic [31:0] t;
        logic [5:0]  op;
        logic [5:0]  fn;
        int          rs, rt, rd, sh, p, g, wa;
        for (int i = 0; i < 32; i++) r[i] = '0;
        p = 0;
        g = -1;
        exp_hlt = 1'b0;
        exp_ill = 1'b0;
        exp_ret = 0;
        for (int s = 0; s < max_steps && !exp_hlt; s++) begin
            ins = ref_mem[p];
            sbq.push_back('{1'b0, p, 32'd0, g});
            p = (p + 1) % MW;
            op = ins[31:26];
            fn = ins[5:0];
            rs = int'(ins[25:21]);
            rt = int'(ins[20:16]);
            rd = int'(ins[15:11]);
            sh = int'(ins[10:6]);
            se = {{16{ins[15]}}, ins[15:0]};
            t  = r[rs] + se;
            wa = int'(t[13:2]);
            g  = 4;
            exp_ret++;
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20: r[rd] = r[rs] + r[rt];
                        6'h22: r[rd] = r[rs] - r[rt];
                        6'h24: r[rd] = r[rs] & r[rt];
                        6'h25: r[rd] = r[rs] | r[rt];
                        6'h2A: r[rd] = ($signed(r[rs]) < $signed(r[rt]))
                                       ? 32'd1 : 32'd0;
                        6'h00: r[rd] = r[rt] << sh;
                        6'h0D: exp_hlt = 1'b1;
                        default: begin
                            exp_hlt = 1'b1;
                            exp_ill = 1'b1;
                        end
                    endcase
                end
                6'h08: r[rt] = t;
                6'h23: begin
                    sbq.push_back('{1'b0, wa, 32'd0, 3});
                    r[rt] = ref_mem[wa];
                    g = 2;
                end
                6'h2B: begin
                    sbq.push_back('{1'b1, wa, r[rt], 3});
                    ref_mem[wa] = r[rt];
                    g = 1;
                end
                6'h04: begin
                    if (r[rs] == r[rt]) p = (p + int'(se[11:0])) % MW;
                    g = 3;
                end
                6'h02: begin
                    p = int'(ins[11:0]);
                    g = 3;
                end
                default: begin
                    exp_hlt = 1'b1;
                    exp_ill = 1'b1;
                end
            endcase
            r[0] = '0;
            if (exp_hlt) exp_ret--;
        end
        exp_pc = p;
    endtask

    task automatic begin_load();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < MW; i++) mem[i] = '0;
    endtask

    task automatic run_prog(input int max_steps, input int budget);
        int n = 0;
        ref_mem = mem;
        sbq.delete();
        model_run(max_steps);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_req", 32'(mem_req), 32'd1);
        check("rel_addr", 32'(mem_addr), 32'd0);
        while (n < budget && !(sbq.size() == 0 && (!exp_hlt || halted === 1'b1)))
        begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL run_timeout: %0d accesses left after %0d cycles",
                     sbq.size(), n);
        end
        if (exp_hlt) begin
            @(negedge clk);
            check("halted", 32'(halted), 32'd1);
            check("illegal", 32'(illegal), 32'(exp_ill));
            check("halt_pc", 32'(pc), 32'(exp_pc));
`ifdef MIPS_MULTICYCLE_PERF_EN
            check("retired", retired_count, 32'(exp_ret));
`endif
            repeat (3) begin
                @(negedge clk);
                check("halt_req", 32'(mem_req), 32'd0);
            end
        end
    endtask

    task automatic gen_random();
        int fl[6] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h00};
        int n = 0;
        int k;
        for (int i = 1; i < 8; i++) mem[n++] = enc_i(8, 0, i, 16'($urandom));
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 4)
                mem[n] = enc_r(fl[$urandom_range(0, 5)], $urandom_range(0, 7),
                               $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 31));
            else if (k == 5)
                mem[n] = enc_i(8, $urandom_range(0, 7), $urandom_range(0, 7),
                               16'($urandom));
            else if (k == 6 || k == 7)
                mem[n] = enc_i((k == 6) ? 32'h23 : 32'h2B, 0,
                               $urandom_range(0, 7),
                               16'(32'h2000 + 4 * $urandom_range(0, 15)
                                   + $urandom_range(0, 3)));
            else if (k == 8)
                mem[n] = enc_i(4, $urandom_range(0, 3), $urandom_range(0, 3),
                               16'($urandom_range(0, 2)));
            else
                mem[n] = enc_j(n + 1 + $urandom_range(0, 2));
            n++;
        end
        for (int i = 0; i < 8; i++)
            mem[n++] = enc_i(32'h2B, 0, i, 16'(32'h2100 + 4 * i));
        mem[n] = 32'h0000_000D;
        for (int i = 0; i < 16; i++) mem[32'h800 + i] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < MW; i++) mem[i] = '0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_req", 32'(mem_req), 32'd0);
            check("rst_pc", 32'(pc), 32'd0);
        end

        // ALU program, zero wait-states
        mem[0] = enc_i(8, 0, 1, 16'd5);
        mem[1] = enc_i(8, 0, 2, 16'hFFFD);
        mem[2] = enc_r(32'h20, 1, 2, 3, 0);
        mem[3] = enc_r(32'h2A, 2, 1, 4, 0);
        mem[4] = enc_r(32'h00, 0, 1, 5, 2);
        mem[5] = enc_i(32'h2B, 0, 3, 16'h0100);
        mem[6] = enc_i(32'h2B, 0, 4, 16'h0104);
        mem[7] = enc_i(32'h2B, 0, 5, 16'h0108);
        mem[8] = 32'h0000_000D;
        run_prog(100, 500);
        check("alu_add", mem[32'h40], 32'd2);
        check("alu_slt", mem[32'h41], 32'd1);
        check("alu_sll", mem[32'h42], 32'd20);

        // Store/load with two wait-states per access
        begin_load();
        mem[0]       = enc_j(32'h100);
        mem[32'h100] = enc_i(8, 0, 1, 16'd5);
        mem[32'h101] = enc_i(32'h2B, 0, 1, 16'd8);
        mem[32'h102] = enc_i(32'h23, 0, 6, 16'd8);
        mem[32'h103] = enc_i(32'h2B, 0, 6, 16'd12);
        mem[32'h104] = 32'h0000_000D;
        fixed_wait = 2;
        run_prog(100, 500);
        fixed_wait = -1;
        check("sw_word2", mem[2], 32'd5);
        check("lw_word3", mem[3], 32'd5);

        // Branch, jump and PC wrap; ends spinning on a beq at word 4
        begin_load();
        mem[0]       = enc_i(4, 7, 0, 16'd2);
        mem[1]       = enc_i(32'h2B, 0, 7, 16'h0100);
        mem[2]       = enc_j(4);
        mem[3]       = enc_j(32'h3FF);
        mem[4]       = enc_i(4, 0, 0, 16'hFFFF);
        mem[32'h3FF] = enc_j(32'hFFF);
        mem[32'hFFF] = enc_i(8, 0, 7, 16'd9);
        run_prog(12, 500);
        repeat (3) @(negedge clk);
        check("loop_req", 32'(mem_req), 32'd1);
        check("loop_addr", 32'(mem_addr), 32'd4);
        check("wrap_store", mem[32'h40], 32'd9);

        // Halt causes and $0 write discard
        begin_load();
        mem[0] = 32'h0000_000D;
        run_prog(10, 200);
        begin_load();
        mem[0] = {6'h3F, 26'd0};
        run_prog(10, 200);
        begin_load();
        mem[0] = enc_i(8, 0, 0, 16'd7);
        mem[1] = enc_i(32'h2B, 0, 0, 16'h0100);
        mem[2] = enc_r(32'h21, 1, 2, 3, 0);
        mem[32'h40] = 32'h1234;
        run_prog(10, 200);
        check("zero_reg", mem[32'h40], 32'd0);

        // Reset while a store is stalled
        begin_load();
        mem[0]       = enc_j(32'h100);
        mem[32'h100] = enc_i(8, 0, 1, 16'd5);
        mem[32'h101] = enc_i(32'h2B, 0, 1, 16'd8);
        mem[2]       = 32'hDEAD_BEEF;
        hold_wr = 1'b1;
        ref_mem = mem;
        sbq.delete();
        model_run(3);
        @(posedge clk);
        #1 reset = 1'b1;
        begin
            int n = 0;
            while (n < 200 && !(mem_req === 1'b1 && mem_we === 1'b1)) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (n >= 200) begin
                miscompares++;
                $display("FAIL store_pending: no store request in %0d cycles", n);
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_mem", mem[2], 32'hDEAD_BEEF);
        check("mid_rst_left", 32'(sbq.size()), 32'd1);
`ifdef MIPS_MULTICYCLE_PERF_EN
        check("mid_rst_cyc", cycle_count, 32'd0);
        check("mid_rst_ret", retired_count, 32'd0);
`endif
        hold_wr = 1'b0;
        mem[0] = enc_i(32'h2B, 0, 1, 16'h0100);
        mem[1] = 32'h0000_000D;
        mem[32'h40] = 32'h5555;
        run_prog(10, 200);
        check("mid_rst_reg", mem[32'h40], 32'd0);

        // Random programs with random wait-states
        for (int it = 0; it < 15; it++) begin
            begin_load();
            gen_random();
            wait_pct = $urandom_range(0, 50);
            run_prog(1000, 20000);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
